mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the core's two memory requesters over one shared single-port bus with a Wishbone-style handshake.
  - IF-stage instruction fetch.
  - MEM-stage data load/store.
- Non-preemptive: one outstanding transaction at a time.
- Raises a pipeline stall request while any requester waits.
- Sits between pc_reg/if_id (fetch side), mem (data side) and the external bus; replaces the direct rom_addr_o/rom_ce_o path.

Parameters:
- ADDR_W, 32, address width of requesters and bus.
- DATA_W, 32, data width; byte-select width is DATA_W/8.
- TIMEOUT_CYC, 255, bus cycles before forced abort (only with MEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; held high until if_ack_o or flush_i.
- if_addr_i  in  ADDR_W  fetch address; stable while if_req_i is high.
- if_rdata_o  out  DATA_W  fetched instruction; valid when if_ack_o is high.
- if_ack_o  out  1  one-cycle completion pulse for fetch.
- dm_req_i  in  1  data request; held high until dm_ack_o.
- dm_we_i  in  1  1 = store, 0 = load.
- dm_sel_i  in  DATA_W/8  byte enables.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  store data.
- dm_rdata_o  out  DATA_W  load data; valid when dm_ack_o is high.
- dm_ack_o  out  1  one-cycle completion pulse for data.
- flush_i  in  1  pipeline flush; cancels any pending or in-flight fetch.
- stallreq_o  out  1  stall request to the pipeline controller.
- bus_err_o  out  1  one-cycle timeout pulse; tied 0 when the feature is off.
- bus_cyc_o, bus_stb_o  out  1  bus cycle and strobe, driven identically.
- bus_we_o  out  1  bus write enable.
- bus_sel_o  out  DATA_W/8  bus byte enables.
- bus_addr_o  out  ADDR_W  bus address.
- bus_wdata_o  out  DATA_W  bus write data.
- bus_rdata_i  in  DATA_W  bus read data.
- bus_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, every output 0, last_grant = IF.
- States:
  - IDLE: no bus activity.
  - IF_BUSY: fetch granted and in flight.
  - DM_BUSY: data access granted and in flight.
  - IF_DROP: flushed fetch; still in flight, result will be discarded.
- Bus outputs are registered. Address, data, sel and we are captured from the granted requester at the grant edge and held constant until the ack edge.
- Grant from IDLE:
  - dm_req_i only → DM_BUSY.
  - if_req_i && !flush_i only → IF_BUSY.
  - Both → the requester not in last_grant.
  - bus_cyc_o rises the cycle after the request is sampled.
- BUSY states:
  - Hold until bus_ack_i is sampled high.
  - On that edge, latch bus_rdata_i into the requester's rdata_o.
  - Pulse that requester's ack_o for exactly 1 cycle and update last_grant.
  - Same edge: if the other requester (or the same one, with a new request) is pending, grant it immediately (back-to-back); bus_cyc_o stays high.
  - Otherwise go to IDLE and drop bus_cyc_o.
- Minimum latency, request to ack_o: 2 cycles (zero-wait slave, ack in the first bus cycle).
- Requester handshake:
  - if_req_i/dm_req_i must stay high with stable payload until ack; the requester may reassert on the cycle after ack.
  - rdata_o holds its last value until the next ack for that port.
- Flush:
  - flush_i in IF_BUSY → IF_DROP. The bus cycle continues until bus_ack_i, because it cannot be abandoned. No if_ack_o is produced, if_rdata_o is unchanged, then arbitration proceeds as normal.
  - flush_i in IDLE or DM_BUSY masks if_req_i that cycle.
  - Data accesses are never flushed.
- stallreq_o = (if_req_i && !if_ack_o && !flush_i) || (dm_req_i && !dm_ack_o) || state == IF_DROP. Combinational from registered state and the inputs.
- Store ack: dm_rdata_o is updated with whatever bus_rdata_i carries; the requester ignores it.
- Reset mid-transaction drops bus_cyc_o immediately; the slave must tolerate an aborted cycle.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - An 8-bit (clog2(TIMEOUT_CYC+1)) counter clears on each grant and increments each BUSY/IF_DROP cycle.
  - When it reaches TIMEOUT_CYC without bus_ack_i: drop bus_cyc_o and pulse bus_err_o plus the granted requester's ack_o. rdata_o is loaded with all-ones. IF_DROP produces bus_err_o only.
  - Then go to IDLE.
- Undefined: no counter; a transaction waits for ack indefinitely; bus_err_o is constant 0.

Decomposition:
- Shared define file:
  - State encodings ArbIdle/ArbIfBusy/ArbDmBusy/ArbIfDrop (2-bit ArbStateBus).
  - Grant encodings GrantIf/GrantDm.
  - Reuse the existing RegBus/InstAddrBus for widths.
- One natural sub-module, mem_arb_timer (timeout counter with clear/enable/expire). It is instantiated only under the macro.

Test Plan:
- Fetch only, slave acks in first bus cycle, if_addr_i=0x00000010, bus_rdata_i=0x3C010101 → bus_addr_o=0x10 at cycle 1, if_ack_o pulse at cycle 2 with if_rdata_o=0x3C010101, stallreq_o high in cycles 0–1.
- Simultaneous if_req_i and dm_req_i from reset (last_grant=IF), store 0xAABBCCDD to 0x100, sel=4'b1111 → DM served first (bus_we_o=1), then IF back-to-back with bus_cyc_o never dropping. Next simultaneous pair grants IF first.
- Slave with 3 wait states on a load from 0x200 returning 0x12345678 → bus signals stable for 4 cycles, single dm_ack_o pulse, dm_rdata_o=0x12345678.
- flush_i asserted 1 cycle into a fetch, slave acks 2 cycles later → no if_ack_o, if_rdata_o unchanged, stallreq_o high until that ack, then IDLE.
- rst pulled low while DM_BUSY → bus_cyc_o, dm_ack_o and stallreq_o go 0 without a clock edge. After release, a new fetch completes normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=4, slave never acks a load → bus_err_o and dm_ack_o pulse after 4 busy cycles, dm_rdata_o=0xFFFFFFFF, bus_cyc_o low.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, state and grant encodings for the memory arbiter.
// Used by mem_arbiter and mem_arb_timer.
package mem_arbiter_pkg;

    localparam int RegBusW      = 32;
    localparam int InstAddrBusW = 32;
    localparam int ArbStateW    = 2;

    typedef logic [RegBusW-1:0]      RegBus;
    typedef logic [InstAddrBusW-1:0] InstAddrBus;
    typedef logic [ArbStateW-1:0]    ArbStateBus;

    typedef enum ArbStateBus {
        ArbIdle   = 2'd0,
        ArbIfBusy = 2'd1,
        ArbDmBusy = 2'd2,
        ArbIfDrop = 2'd3
    } arb_state_e;

    typedef enum logic {
        GrantIf = 1'b0,
        GrantDm = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Bus-cycle watchdog: counts busy cycles since the last grant.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Clear on grant, otherwise count each busy cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one Wishbone-style bus, non-preemptive.
// MEM_ARB_TIMEOUT_EN adds a watchdog that aborts hung bus cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = InstAddrBusW,
    parameter int DATA_W      = RegBusW,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_ack_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [DATA_W/8-1:0] dm_sel_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                dm_ack_o,
    input  logic                flush_i,
    output logic                stallreq_o,
    output logic                bus_err_o,
    output logic                bus_cyc_o,
    output logic                bus_stb_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_ack_i
);

    localparam int SEL_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    grant_e            last_q, last_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic              err_q, err_d;

    logic if_pend, dm_pend;
    logic done, drop;
    logic served_if, served_dm;
    logic want_if, want_dm;
    logic pick_if, pick_dm;
    logic grant;
    logic expire;

`ifdef MEM_ARB_TIMEOUT_EN
    logic tmr_exp;

    mem_arb_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (grant),
        .en_i     (state_q != ArbIdle),
        .expire_o (tmr_exp)
    );

    assign expire = tmr_exp && !bus_ack_i;
`else
    logic unused_tmr;

    assign unused_tmr = grant ^ (TIMEOUT_CYC == 0);
    assign expire     = 1'b0;
`endif

    assign grant = pick_if || pick_dm;

    // Next state: completion, flush handling and round-robin grant.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        err_d      = 1'b0;
        done       = 1'b0;
        served_if  = 1'b0;
        served_dm  = 1'b0;
        pick_if    = 1'b0;
        pick_dm    = 1'b0;

        // A request still high in its own ack cycle is the old one.
        if_pend = if_req_i && !flush_i && !if_ack_q;
        dm_pend = dm_req_i && !dm_ack_q;
        drop    = (state_q == ArbIfDrop)
               || (state_q == ArbIfBusy && flush_i);

        unique case (state_q)
            ArbIdle: begin
                done = 1'b1;
            end
            ArbIfBusy, ArbIfDrop: begin
                if (bus_ack_i || expire) begin
                    done      = 1'b1;
                    served_if = (state_q == ArbIfBusy);
                    err_d     = !bus_ack_i;
                    if (!drop) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus_ack_i ? bus_rdata_i : '1;
                        last_d     = GrantIf;
                    end
                end else if (drop) begin
                    state_d = ArbIfDrop;
                end
            end
            ArbDmBusy: begin
                if (bus_ack_i || expire) begin
                    done       = 1'b1;
                    served_dm  = 1'b1;
                    err_d      = !bus_ack_i;
                    dm_ack_d   = 1'b1;
                    dm_rdata_d = bus_ack_i ? bus_rdata_i : '1;
                    last_d     = GrantDm;
                end
            end
            default: begin
                state_d = ArbIdle;
            end
        endcase

        want_if = if_pend && !served_if;
        want_dm = dm_pend && !served_dm;

        if (done) begin
            if (want_if && want_dm) begin
                pick_dm = (last_d == GrantIf);
                pick_if = !pick_dm;
            end else begin
                pick_if = want_if;
                pick_dm = want_dm;
            end

            if (pick_if) begin
                state_d = ArbIfBusy;
                cyc_d   = 1'b1;
                we_d    = 1'b0;
                sel_d   = '1;
                addr_d  = if_addr_i;
                wdata_d = '0;
            end else if (pick_dm) begin
                state_d = ArbDmBusy;
                cyc_d   = 1'b1;
                we_d    = dm_we_i;
                sel_d   = dm_sel_i;
                addr_d  = dm_addr_i;
                wdata_d = dm_wdata_i;
            end else begin
                state_d = ArbIdle;
                cyc_d   = 1'b0;
            end
        end
    end

    // State, bus and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ArbIdle;
            last_q     <= GrantIf;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            err_q      <= err_d;
        end
    end

    assign stallreq_o = rst && (
        (if_req_i && !if_ack_q && !flush_i)
        || (dm_req_i && !dm_ack_q)
        || (state_q == ArbIfDrop));

    assign if_rdata_o  = if_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_ack_o    = dm_ack_q;
    assign bus_err_o   = err_q;
    assign bus_cyc_o   = cyc_q;
    assign bus_stb_o   = cyc_q;
    assign bus_we_o    = we_q;
    assign bus_sel_o   = sel_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus
// randomized fetch/data traffic against a memory reference model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_sel;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        flush;
    logic        stallreq_o;
    logic        bus_err_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req_i(if_req),
        .if_addr_i(if_addr),
        .if_rdata_o(if_rdata_o),
        .if_ack_o(if_ack_o),
        .dm_req_i(dm_req),
        .dm_we_i(dm_we),
        .dm_sel_i(dm_sel),
        .dm_addr_i(dm_addr),
        .dm_wdata_i(dm_wdata),
        .dm_rdata_o(dm_rdata_o),
        .dm_ack_o(dm_ack_o),
        .flush_i(flush),
        .stallreq_o(stallreq_o),
        .bus_err_o(bus_err_o),
        .bus_cyc_o(bus_cyc_o),
        .bus_stb_o(bus_stb_o),
        .bus_we_o(bus_we_o),
        .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Bus slave: programmable wait states, byte-merged writes.
    logic [31:0] smem [logic [31:0]];
    int          wait_states = 0;
    int          ws_cnt = 0;
    bit          slave_hang = 0;
    bit          rand_ws = 0;
    logic [31:0] sv_old;

    always @(negedge clk) begin
        if (bus_cyc_o && !slave_hang && ws_cnt >= wait_states) begin
            sv_old = smem.exists(bus_addr_o) ? smem[bus_addr_o]
                                             : dflt(bus_addr_o);
            bus_ack_i = 1'b1;
            bus_rdata_i = sv_old;
            if (bus_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus_sel_o[b])
                        sv_old[8*b +: 8] = bus_wdata_o[8*b +: 8];
                smem[bus_addr_o] = sv_old;
            end
            ws_cnt = 0;
            if (rand_ws) wait_states = $urandom_range(0, 2);
        end else if (bus_cyc_o && !slave_hang) begin
            bus_ack_i = 1'b0;
            ws_cnt++;
        end else begin
            bus_ack_i = 1'b0;
            ws_cnt = 0;
        end
    end

    // Protocol monitor active during random traffic.
    bit mon_en = 0;

    always @(negedge clk) begin
        if (mon_en && rst) begin
            chk("stall_rule", stallreq_o,
                (if_req && !if_ack_o && !flush) || (dm_req && !dm_ack_o));
            chk("one_ack", if_ack_o & dm_ack_o, 0);
            chk("stb_eq_cyc", bus_stb_o, bus_cyc_o);
`ifndef MEM_ARB_TIMEOUT_EN
            chk("no_err", bus_err_o, 0);
`endif
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        if_req = 0; if_addr = '0; flush = 0;
        dm_req = 0; dm_we = 0; dm_sel = '0;
        dm_addr = '0; dm_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic fetch_agent();
        int gap;
        int cnt;
        logic [31:0] a;
        for (int n = 0; n < 150; n++) begin
            gap = $urandom_range(1, 3);
            repeat (gap) tick();
            a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
            if_addr = a;
            if_req = 1;
            cnt = 0;
            do begin
                tick();
                cnt++;
            end while (!if_ack_o && cnt < 200);
            chk("rnd_if_done", if_ack_o, 1);
            if (if_ack_o) chk("rnd_if_rdata", if_rdata_o, dflt(a));
            if_req = 0;
        end
    endtask

    logic [31:0] rmem [logic [31:0]];

    task automatic data_agent();
        int gap;
        int cnt;
        logic [31:0] a, wd, exp;
        logic [3:0] s;
        logic we;
        for (int n = 0; n < 150; n++) begin
            gap = $urandom_range(1, 3);
            repeat (gap) tick();
            a  = 32'h8000 + 32'($urandom_range(0, 15)) * 4;
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            s  = we ? 4'($urandom_range(1, 15)) : 4'hF;
            dm_addr = a; dm_we = we; dm_wdata = wd; dm_sel = s;
            dm_req = 1;
            cnt = 0;
            do begin
                tick();
                cnt++;
            end while (!dm_ack_o && cnt < 200);
            chk("rnd_dm_done", dm_ack_o, 1);
            exp = rmem.exists(a) ? rmem[a] : dflt(a);
            if (dm_ack_o) begin
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) exp[8*b +: 8] = wd[8*b +: 8];
                    rmem[a] = exp;
                end else begin
                    chk("rnd_dm_rdata", dm_rdata_o, exp);
                end
            end
            dm_req = 0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        smem[32'h10]  = 32'h3C010101;
        smem[32'h200] = 32'h12345678;
        smem[32'h204] = 32'h0BADF00D;
        smem[32'h30]  = 32'hCAFE0030;
        smem[32'h40]  = 32'hDEAD0040;

        // Reset state
        rst = 1'b0;
        if_req = 0; if_addr = '0; flush = 0;
        dm_req = 0; dm_we = 0; dm_sel = '0;
        dm_addr = '0; dm_wdata = '0;
        #13;
        chk("rst_cyc", bus_cyc_o, 0);
        chk("rst_acks", {if_ack_o, dm_ack_o, bus_err_o}, 0);
        chk("rst_stall", stallreq_o, 0);
        chk("rst_bus", {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, 0);
        chk("rst_rdata", {if_rdata_o, dm_rdata_o}, 0);

        // Fetch only, zero-wait slave
        do_reset();
        if_req = 1; if_addr = 32'h10;
        #1 chk("t1_stall_c0", stallreq_o, 1);
        tick();
        chk("t1_cyc_c1", bus_cyc_o, 1);
        chk("t1_addr_c1", bus_addr_o, 32'h10);
        chk("t1_stall_c1", stallreq_o, 1);
        tick();
        chk("t1_ack_c2", if_ack_o, 1);
        chk("t1_rdata", if_rdata_o, 32'h3C010101);
        chk("t1_cyc_c2", bus_cyc_o, 0);
        if_req = 0;
        tick();
        chk("t1_ack_pulse", if_ack_o, 0);

        // Simultaneous requests from reset: data wins, then fetch
        do_reset();
        if_req = 1; if_addr = 32'h20;
        dm_req = 1; dm_we = 1; dm_addr = 32'h100;
        dm_wdata = 32'hAABBCCDD; dm_sel = 4'hF;
        tick();
        chk("t2_dm_first", {bus_cyc_o, bus_we_o, bus_addr_o}, {2'b11, 32'h100});
        chk("t2_wdata", {bus_sel_o, bus_wdata_o}, {4'hF, 32'hAABBCCDD});
        tick();
        chk("t2_dm_ack", dm_ack_o, 1);
        chk("t2_b2b_if", {bus_cyc_o, bus_we_o, bus_addr_o}, {2'b10, 32'h20});
        dm_req = 0;
        tick();
        chk("t2_if_ack", if_ack_o, 1);
        chk("t2_if_rdata", if_rdata_o, dflt(32'h20));
        chk("t2_cyc_off", bus_cyc_o, 0);
        chk("t2_store_mem", smem[32'h100], 32'hAABBCCDD);
        if_req = 0;
        tick();
        dm_req = 1; dm_we = 0; dm_addr = 32'h100; dm_sel = 4'hF;
        tick();
        tick();
        chk("t2_load_back", {dm_ack_o, dm_rdata_o}, {1'b1, 32'hAABBCCDD});
        dm_req = 0;
        tick();
        if_req = 1; if_addr = 32'h30;
        dm_req = 1; dm_we = 0; dm_addr = 32'h204;
        tick();
        chk("t2_if_first", {bus_cyc_o, bus_we_o, bus_addr_o}, {2'b10, 32'h30});
        tick();
        chk("t2_if_ack2", {if_ack_o, if_rdata_o}, {1'b1, 32'hCAFE0030});
        chk("t2_b2b_dm", {bus_cyc_o, bus_addr_o}, {1'b1, 32'h204});
        if_req = 0;
        tick();
        chk("t2_dm_ack2", {dm_ack_o, dm_rdata_o}, {1'b1, 32'h0BADF00D});
        dm_req = 0;
        tick();

        // Load with three wait states
        wait_states = 3;
        dm_req = 1; dm_we = 0; dm_addr = 32'h200; dm_sel = 4'hF;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold", {bus_cyc_o, bus_we_o, bus_addr_o, dm_ack_o},
                {2'b10, 32'h200, 1'b0});
            tick();
        end
        chk("t3_ack", {dm_ack_o, dm_rdata_o}, {1'b1, 32'h12345678});
        chk("t3_cyc_off", bus_cyc_o, 0);
        dm_req = 0;
        tick();
        chk("t3_ack_pulse", dm_ack_o, 0);

        // Flush one cycle into a fetch
        wait_states = 2;
        if_req = 1; if_addr = 32'h40;
        tick();
        chk("t4_cyc", bus_cyc_o, 1);
        if_req = 0; flush = 1;
        tick();
        flush = 0;
        #1 chk("t4_stall_c2", stallreq_o, 1);
        tick();
        chk("t4_stall_c3", {stallreq_o, bus_cyc_o}, 2'b11);
        tick();
        chk("t4_idle", {stallreq_o, bus_cyc_o, if_ack_o}, 3'b000);
        chk("t4_rdata_kept", if_rdata_o, 32'hCAFE0030);
        tick();
        chk("t4_no_ack", if_ack_o, 0);
        wait_states = 0;

        // Asynchronous reset during a data access
        slave_hang = 1;
        dm_req = 1; dm_we = 0; dm_addr = 32'h200;
        tick();
        chk("t5_busy", bus_cyc_o, 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_async", {bus_cyc_o, bus_stb_o, dm_ack_o, stallreq_o}, 0);
        dm_req = 0;
        slave_hang = 0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        if_req = 1; if_addr = 32'h10;
        tick();
        chk("t5_refetch_cyc", {bus_cyc_o, bus_addr_o}, {1'b1, 32'h10});
        tick();
        chk("t5_refetch", {if_ack_o, if_rdata_o}, {1'b1, 32'h3C010101});
        if_req = 0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Hung slave: watchdog aborts after four busy cycles
        slave_hang = 1;
        dm_req = 1; dm_we = 0; dm_addr = 32'h300;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t6_busy", {bus_cyc_o, bus_err_o, dm_ack_o}, 3'b100);
            tick();
        end
        chk("t6_abort", {bus_err_o, dm_ack_o, bus_cyc_o}, 3'b110);
        chk("t6_rdata", dm_rdata_o, 32'hFFFFFFFF);
        dm_req = 0;
        slave_hang = 0;
        tick();
        chk("t6_err_pulse", bus_err_o, 0);
`else
        chk("t6_no_err", bus_err_o, 0);
`endif

        // Randomized concurrent traffic
        rand_ws = 1;
        mon_en = 1;
        fork
            fetch_agent();
            data_agent();
        join
        mon_en = 0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
